udp_tx_arbiter: RTL

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_tx_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin N:1 arbiter for UDP TX header + payload streams.
// A grant covers exactly one packet (header, then payload up to tlast).
// Forward paths are purely combinational muxes; nothing is buffered.

// Per-source ready gating: a lane sees downstream ready only while granted
// and only for the stream belonging to the current phase.
module udp_tx_arbiter_lane (
    input  logic i_sel,
    input  logic i_hdr_phase,
    input  logic i_pay_phase,
    input  logic i_m_hdr_ready,
    input  logic i_m_tready,
    output logic o_hdr_ready,
    output logic o_tready
);
    assign o_hdr_ready = i_sel & i_hdr_phase & i_m_hdr_ready;
    assign o_tready    = i_sel & i_pay_phase & i_m_tready;
endmodule

module udp_tx_arbiter #(
    parameter int NUM_SOURCES = 2,
    parameter int TUSER_WIDTH = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_SOURCES-1:0]                  s_hdr_valid,
    output logic [NUM_SOURCES-1:0]                  s_hdr_ready,
    input  logic [NUM_SOURCES-1:0][31:0]            s_hdr_dest_ip,
    input  logic [NUM_SOURCES-1:0][15:0]            s_hdr_source_port,
    input  logic [NUM_SOURCES-1:0][15:0]            s_hdr_dest_port,
    input  logic [NUM_SOURCES-1:0][15:0]            s_hdr_length,
    input  logic [NUM_SOURCES-1:0][7:0]             s_tdata,
    input  logic [NUM_SOURCES-1:0]                  s_tvalid,
    output logic [NUM_SOURCES-1:0]                  s_tready,
    input  logic [NUM_SOURCES-1:0]                  s_tlast,
    input  logic [NUM_SOURCES-1:0][TUSER_WIDTH-1:0] s_tuser,
    output logic                                    m_hdr_valid,
    input  logic                                    m_hdr_ready,
    output logic [31:0]                             m_hdr_dest_ip,
    output logic [15:0]                             m_hdr_source_port,
    output logic [15:0]                             m_hdr_dest_port,
    output logic [15:0]                             m_hdr_length,
    output logic [7:0]                              m_tdata,
    output logic                                    m_tvalid,
    input  logic                                    m_tready,
    output logic                                    m_tlast,
    output logic [TUSER_WIDTH-1:0]                  m_tuser,
    output logic [$clog2(NUM_SOURCES)-1:0]          grant_index,
    output logic                                    busy
);
    localparam int GW = $clog2(NUM_SOURCES);

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_t;

    state_t        r_state, w_state_nxt;
    logic [GW-1:0] r_grant, r_ptr, w_pick;
    logic [GW:0]   w_cand;
    logic          w_found, w_hdr_hs, w_last_hs, w_hdr_phase, w_pay_phase;

    // Round-robin search: first requester at or above the pointer, wrapping.
    // One extra bit on the candidate lets the wrap work for non-power-of-two N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            w_cand = {1'b0, r_ptr} + (GW+1)'(k);
            if (w_cand >= (GW+1)'(NUM_SOURCES))
                w_cand = w_cand - (GW+1)'(NUM_SOURCES);
            if (!w_found && s_hdr_valid[w_cand[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[GW-1:0];
            end
        end
    end

    assign w_hdr_phase = (r_state == ST_HEADER);
    assign w_pay_phase = (r_state == ST_PAYLOAD);
    assign w_hdr_hs    = s_hdr_valid[r_grant] & m_hdr_ready;
    assign w_last_hs   = s_tvalid[r_grant] & m_tready & s_tlast[r_grant];

    // State register; reset abandons any packet in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: a dropped header valid just stalls HEADER, no re-arbitration
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_found)   w_state_nxt = ST_HEADER;
            ST_HEADER:  if (w_hdr_hs)  w_state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: if (w_last_hs) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant latched at arbitration; pointer moves past the winner on tlast
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_found)
                r_grant <= w_pick;
            if (r_state == ST_PAYLOAD && w_last_hs)
                r_ptr <= (r_grant == GW'(NUM_SOURCES - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    // Output mux: granted source forwarded in its phase, zeros otherwise
    always_comb begin
        m_hdr_valid       = 1'b0;
        m_hdr_dest_ip     = '0;
        m_hdr_source_port = '0;
        m_hdr_dest_port   = '0;
        m_hdr_length      = '0;
        m_tdata           = '0;
        m_tvalid          = 1'b0;
        m_tlast           = 1'b0;
        m_tuser           = '0;
        if (w_hdr_phase) begin
            m_hdr_valid       = s_hdr_valid[r_grant];
            m_hdr_dest_ip     = s_hdr_dest_ip[r_grant];
            m_hdr_source_port = s_hdr_source_port[r_grant];
            m_hdr_dest_port   = s_hdr_dest_port[r_grant];
            m_hdr_length      = s_hdr_length[r_grant];
        end
        if (w_pay_phase) begin
            m_tdata  = s_tdata[r_grant];
            m_tvalid = s_tvalid[r_grant];
            m_tlast  = s_tlast[r_grant];
            m_tuser  = s_tuser[r_grant];
        end
    end

    assign grant_index = r_grant;
    assign busy        = (r_state != ST_IDLE);

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_lane
        udp_tx_arbiter_lane u_lane (
            .i_sel         (r_grant == GW'(g)),
            .i_hdr_phase   (w_hdr_phase),
            .i_pay_phase   (w_pay_phase),
            .i_m_hdr_ready (m_hdr_ready),
            .i_m_tready    (m_tready),
            .o_hdr_ready   (s_hdr_ready[g]),
            .o_tready      (s_tready[g])
        );
    end
endmodule
